inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, SHALL set the number of fetched-instruction buffer entries (legal values 2 and 4).
REQ-002 Parameter NOP_INST, default 32'h00000013, SHALL set the value driven on inst when the buffer is empty.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 _Rest  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 PCWre  input  1  SHALL be the PC-write strobe from the address generation unit (new fetch address valid).
REQ-006 address  input  32  SHALL be the fetch address from the address generation unit, sampled when PCWre=1.
REQ-007 fetch_busy  output  1  SHALL tell the address generation unit that PCWre is not accepted this cycle.
REQ-008 imem_req  output  1, imem_addr  output  32: SHALL form the instruction-memory request.
REQ-009 imem_gnt  input  1, imem_rvalid  input  1, imem_rdata  input  32: SHALL form the memory grant and response.
REQ-010 flush  input  1  SHALL discard all buffered and in-flight instructions.
REQ-011 inst_valid  output  1, inst  output  32, inst_pc  output  32, inst_misalign  output  1: SHALL present the buffer head to decode.
REQ-012 inst_ready  input  1  SHALL be the decode accept; an entry pops when inst_valid && inst_ready.

Function
REQ-013 The fetch FSM SHALL have states IDLE, REQ and WAIT, with at most one outstanding memory request.
REQ-014 fetch_busy SHALL be 1 when the state is not IDLE, when the buffer count equals FIFO_DEPTH, or when flush=1.
REQ-015 In IDLE, PCWre=1 with fetch_busy=0 and address[1:0]==0 SHALL latch address into imem_addr and go to REQ.
REQ-016 In IDLE, PCWre=1 with fetch_busy=0 and address[1:0]!=0 SHALL issue no request and SHALL push {pc=address, inst=NOP_INST, misalign=1} on the next edge.
REQ-017 PCWre=1 while fetch_busy=1 SHALL be ignored; the address generation unit holds its value.
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr stable; imem_gnt=1 SHALL move to WAIT.
REQ-019 In WAIT, imem_req SHALL be 0; imem_rvalid=1 SHALL push {imem_addr, imem_rdata, misalign=0} and return to IDLE.
REQ-020 Minimum latency: PCWre accepted at edge N, imem_req=1 during cycle N+1, imem_gnt at edge N+1, imem_rvalid at edge N+2, inst_valid=1 during cycle N+3.
REQ-021 The buffer SHALL be a FIFO of FIFO_DEPTH entries {pc[31:0], inst[31:0], misalign}, with wrap-around read and write pointers and count 0..FIFO_DEPTH.
REQ-022 Push and pop on the same edge SHALL leave count unchanged; pop with count 0 SHALL be impossible because inst_valid=0.
REQ-023 A push SHALL never occur at count==FIFO_DEPTH; this is guaranteed by REQ-014, since count cannot rise between issue and response.
REQ-024 When empty: inst_valid=0, inst=NOP_INST, inst_pc=0, inst_misalign=0.
REQ-025 flush=1 at an edge SHALL clear count and pointers, and SHALL suppress any push from REQ-016 or REQ-019 on that edge.
REQ-026 Flush in REQ or WAIT SHALL keep the handshake running (no request withdrawal) and SHALL set a drop flag so the response is discarded; the drop flag clears on that response.
REQ-027 Flush in IDLE with PCWre=1 SHALL not accept the address.

Reset
REQ-028 _Rest=0 SHALL immediately force: state IDLE, imem_req=0, imem_addr=0, count=0, pointers=0, drop flag=0, inst_valid=0, inst=NOP_INST, inst_pc=0, inst_misalign=0.
REQ-029 While _Rest=0, fetch_busy SHALL be 1.
REQ-030 Reset asserted in REQ or WAIT SHALL abandon the request, with no later push.
REQ-031 Reset SHALL release synchronously to CLK, and the first PCWre SHALL be accepted on the first edge after release.

Verification
REQ-032 Reset, then PCWre=1 with address=0x00000000, gnt immediate, rvalid next cycle with rdata=0x00500093 -> inst_valid=1, inst=0x00500093, inst_pc=0 in cycle N+3.
REQ-033 Fetch 0x0, 0x4 and 0x8 with inst_ready=0 and FIFO_DEPTH=2 -> the third PCWre sees fetch_busy=1 until one pop, and no entry is lost.
REQ-034 PCWre with address=0x00000006 -> imem_req stays 0, inst_valid=1, inst_misalign=1, inst_pc=0x6, inst=0x00000013.
REQ-035 Flush asserted in WAIT, rvalid arrives 3 cycles later -> no push and inst_valid stays 0; the next PCWre is accepted.
REQ-036 Count 1 with inst_ready=1 and rvalid on the same edge -> count stays 1, and inst advances to the new entry.
REQ-037 _Rest dropped in WAIT, then released -> all outputs hold reset values and the late rvalid is ignored.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: address-generation handshake, instruction-memory request/response,
// and the decode-side buffer head. The fetch unit uses the master modport.
interface inst_fetch_if;
    logic        PCWre;
    logic [31:0] address;
    logic        fetch_busy;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_misalign;
    logic        inst_ready;

    // Handshakes: a PCWre is taken only on an edge where fetch_busy=0; imem_req is held with a
    // stable imem_addr until the edge with imem_gnt=1; one imem_rvalid follows per grant; an entry
    // leaves the buffer on an edge where inst_valid && inst_ready.
    modport master (
        input  PCWre, address, imem_gnt, imem_rvalid, imem_rdata, flush, inst_ready,
        output fetch_busy, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_misalign
    );
    modport slave (
        output PCWre, address, imem_gnt, imem_rvalid, imem_rdata, flush, inst_ready,
        input  fetch_busy, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_misalign
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory request FSM feeding a small FIFO of
// {pc, inst, misalign} entries presented to decode.
module inst_fetch #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic         CLK,
    input  logic         _Rest,
    inst_fetch_if.master bus,
    output logic [1:0]   fetch_state_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          drop_q, drop_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [64:0]   mem_q [FIFO_DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   push_pc;
    logic [31:0]   push_inst;
    logic          push_mis;
    logic [64:0]   head;

    assign bus.fetch_busy = !_Rest || (state_q != S_IDLE) || (count_q == CW'(FIFO_DEPTH)) || bus.flush;
    assign accept         = bus.PCWre && !bus.fetch_busy;
    assign bus.imem_req   = (state_q == S_REQ);
    assign bus.imem_addr  = addr_q;
    assign fetch_state_o  = state_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        drop_d    = drop_q;
        push      = 1'b0;
        push_pc   = addr_q;
        push_inst = bus.imem_rdata;
        push_mis  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.address[1:0] == 2'b00) begin
                        state_d = S_REQ;
                        addr_d  = bus.address;
                    end else begin
                        push      = 1'b1;
                        push_pc   = bus.address;
                        push_inst = NOP_INST;
                        push_mis  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // A flush never withdraws the request; the response is just marked for discard.
                if (bus.imem_gnt) state_d = S_WAIT;
                if (bus.flush)    drop_d  = 1'b1;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = S_IDLE;
                    push    = !drop_q && !bus.flush;
                    drop_d  = 1'b0;
                end else if (bus.flush) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop = bus.inst_valid && bus.inst_ready;

    always_ff @(posedge CLK or negedge _Rest) begin
        if (!_Rest) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            drop_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                if (push && !pop)      count_q <= count_q + CW'(1);
                else if (!push && pop) count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge CLK) begin
        if (push && !bus.flush) mem_q[wr_ptr_q] <= {push_pc, push_inst, push_mis};
    end

    assign head              = mem_q[rd_ptr_q];
    assign bus.inst_valid    = (count_q != '0);
    assign bus.inst_pc       = bus.inst_valid ? head[64:33] : 32'd0;
    assign bus.inst          = bus.inst_valid ? head[32:1]  : NOP_INST;
    assign bus.inst_misalign = bus.inst_valid ? head[0]     : 1'b0;
endmodule
